fwrisc_dmem_target: RTL and testbench
=====================================

FWRISC_DMEM_TARGET -- requirements
Module: fwrisc_dmem_target

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 32-bit words of storage; power of two, 16..65536.
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0; aligned to 4*MEM_WORDS.
REQ-003 Parameter WAIT_STATES, default 1: extra cycles inserted before dready; legal range 0..15.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high; ports are named clock and reset.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 daddr  input  32  byte address of the request.
REQ-008 dvalid  input  1  request valid; held by the initiator until dready.
REQ-009 dwrite  input  1  1 = write, 0 = read.
REQ-010 dwdata  input  32  write data, lane-aligned.
REQ-011 dwstb  input  4  byte write strobes; bit i enables dwdata[8i+7:8i].
REQ-012 drdata  output  32  read data; valid only while dready=1.
REQ-013 dready  output  1  single-cycle completion pulse.
REQ-014 err  output  1  sticky flag set by any out-of-range access.
REQ-015 err_addr  output  32  daddr of the first out-of-range access since reset.

Function
REQ-016 The block SHALL implement states IDLE, WAIT and RESP.
REQ-017 In IDLE with dvalid=1, the block SHALL latch daddr, dwrite, dwdata and dwstb, load wait counter with WAIT_STATES, and go to WAIT, or go directly to RESP when WAIT_STATES=0.
REQ-018 In WAIT the counter SHALL decrement each cycle; on the cycle it reads 1 the next state SHALL be RESP.
REQ-019 dready SHALL be 1 for exactly one cycle in RESP, exactly WAIT_STATES+1 cycles after the acceptance cycle.
REQ-020 RESP SHALL always return to IDLE; a new request SHALL be accepted no earlier than the cycle after RESP.
REQ-021 Changes on request inputs after acceptance SHALL be ignored until the next acceptance.
REQ-022 An address is in range when BASE_ADDR <= daddr < BASE_ADDR+4*MEM_WORDS; word index = (daddr-BASE_ADDR)[log2(MEM_WORDS)+1:2]; daddr[1:0] ignored.
REQ-023 An in-range write SHALL update only the byte lanes with dwstb=1, on the edge entering RESP; dwstb=4'b0000 SHALL leave memory unchanged and still complete.
REQ-024 An in-range read SHALL present the full stored word on drdata during RESP, reflecting all writes completed earlier.
REQ-025 An out-of-range read SHALL return 32'hDEAD_BEEF; an out-of-range write SHALL be discarded; both SHALL complete normally with dready.
REQ-026 Any out-of-range access SHALL set err; err_addr SHALL be captured only when err was 0.
REQ-027 drdata SHALL be 0 in every cycle dready=0.

Reset
REQ-028 Reset SHALL force state IDLE, counter 0, dready 0, drdata 0, err 0, err_addr 0.
REQ-029 Reset asserted mid-request SHALL abandon the request with no dready and no memory write; storage contents SHALL NOT be reset.

Structure
REQ-030 State encoding, the 32'hDEAD_BEEF constant and the WAIT_STATES width SHALL live in the shared package fwrisc_dbus_pkg.
REQ-031 Storage SHALL be the sub-module fwrisc_dmem_ram: synchronous read, per-byte write enables, one read/write port, no reset.

Verification
REQ-032 WAIT_STATES=1: write 32'h1122_3344, dwstb=4'hF to 32'h8000_0010 -> dready in the 2nd cycle after acceptance; read back 32'h1122_3344.
REQ-033 Partial write: dwstb=4'b0100, dwdata=32'h00AA_0000 to the same word -> read returns 32'h11AA_3344.
REQ-034 WAIT_STATES=0 and 15: read request -> dready exactly 1 and 16 cycles after acceptance, one cycle wide, drdata=0 otherwise.
REQ-035 Read from 32'h7FFF_FFFC, then write to 32'h9000_0000 -> first returns 32'hDEAD_BEEF; err=1; err_addr=32'h7FFF_FFFC; no memory word changes.
REQ-036 Reset asserted during WAIT of a write to 32'h8000_0020 -> no dready, word unchanged, all outputs at reset values; next request completes normally.
REQ-037 Initiator changes daddr and dwdata during WAIT -> originally latched values are used.

Source files
------------

// File: rtl/fwrisc_dbus_pkg.sv
// rtl/fwrisc_dbus_pkg.sv - shared state encoding, constants and address helper for the data-bus target
package fwrisc_dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dbus_state_e;

  localparam int          WS_W      = 4;
  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

  // Unsigned offset compare also rejects addresses below base (they wrap to large offsets).
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
    logic [31:0] off;
    off = addr - base;
    return off < span;
  endfunction

endpackage

// File: rtl/fwrisc_dmem_target_if.sv
// rtl/fwrisc_dmem_target_if.sv - data-bus request/response and error status bundle
interface fwrisc_dmem_target_if;
  logic [31:0] daddr;
  logic        dvalid;
  logic        dwrite;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic [31:0] drdata;
  logic        dready;
  logic        err;
  logic [31:0] err_addr;

  modport master (
    output daddr, dvalid, dwrite, dwdata, dwstb,
    input  drdata, dready, err, err_addr
  );

  modport slave (
    input  daddr, dvalid, dwrite, dwdata, dwstb,
    output drdata, dready, err, err_addr
  );
endinterface

// File: rtl/fwrisc_dmem_ram.sv
// rtl/fwrisc_dmem_ram.sv - single-port word RAM, synchronous read, per-byte write enables, no reset
module fwrisc_dmem_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fwrisc_dmem_target.sv
// rtl/fwrisc_dmem_target.sv - wait-stated data-memory target with out-of-range error capture
module fwrisc_dmem_target
  import fwrisc_dbus_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_STATES = 1
) (
  input logic                  clock,
  input logic                  reset,
  fwrisc_dmem_target_if.slave  bus
);

  localparam int              AW      = $clog2(MEM_WORDS);
  localparam logic [31:0]     SPAN    = 32'(4 * MEM_WORDS);
  localparam logic [WS_W-1:0] WS_INIT = WS_W'(WAIT_STATES);
  localparam logic [WS_W-1:0] CNT_ONE = WS_W'(1);

  dbus_state_e     state_q, state_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstb_q, wstb_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic [31:0] cur_addr, cur_wdata, cur_off, ram_rdata;
  logic [3:0]  cur_wstb;
  logic        cur_write, cur_in_range, go_resp;
  logic        unused_off_bits;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstb_q     <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstb_q     <= wstb_d;
      write_q    <= write_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // With zero wait states the RAM access happens on the acceptance edge, so it sees the live bus.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr  = bus.daddr;
      cur_write = bus.dwrite;
      cur_wdata = bus.dwdata;
      cur_wstb  = bus.dwstb;
    end else begin
      cur_addr  = addr_q;
      cur_write = write_q;
      cur_wdata = wdata_q;
      cur_wstb  = wstb_q;
    end
  end

  assign cur_in_range    = in_window(cur_addr, BASE_ADDR, SPAN);
  assign cur_off         = cur_addr - BASE_ADDR;
  assign unused_off_bits = ^{cur_off[31:AW+2], cur_off[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstb_d     = wstb_q;
    write_d    = write_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    go_resp    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.dvalid) begin
          addr_d  = bus.daddr;
          write_d = bus.dwrite;
          wdata_d = bus.dwdata;
          wstb_d  = bus.dwstb;
          if (WS_INIT == '0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (go_resp && !cur_in_range) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = cur_addr;
    end
  end

  always_comb begin
    bus.dready = 1'b0;
    bus.drdata = '0;
    if (state_q == ST_RESP) begin
      bus.dready = 1'b1;
      if (!write_q) bus.drdata = cur_in_range ? ram_rdata : OOR_RDATA;
    end
  end

  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;

  fwrisc_dmem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .en    (go_resp),
    .we    ((cur_write && cur_in_range) ? cur_wstb : 4'b0000),
    .addr  (cur_off[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_fwrisc_dmem_target.sv
// tb/tb_fwrisc_dmem_target.sv - randomized bench driving three wait-state configurations against a memory model
module tb_fwrisc_dmem_target;

  localparam int          WORDS = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] SPAN  = 32'd256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] daddr  = '0;
  logic [31:0] dwdata = '0;
  logic        dwrite = 1'b0;
  logic [3:0]  dwstb  = '0;
  logic [2:0]  dvalid = '0;

  logic [31:0] rd  [3];
  logic [31:0] era [3];
  logic [2:0]  rdy;
  logic [2:0]  er;

  fwrisc_dmem_target_if b0 ();
  fwrisc_dmem_target_if b1 ();
  fwrisc_dmem_target_if b2 ();

  assign b0.daddr = daddr;  assign b0.dwrite = dwrite; assign b0.dwdata = dwdata;
  assign b0.dwstb = dwstb;  assign b0.dvalid = dvalid[0];
  assign b1.daddr = daddr;  assign b1.dwrite = dwrite; assign b1.dwdata = dwdata;
  assign b1.dwstb = dwstb;  assign b1.dvalid = dvalid[1];
  assign b2.daddr = daddr;  assign b2.dwrite = dwrite; assign b2.dwdata = dwdata;
  assign b2.dwstb = dwstb;  assign b2.dvalid = dvalid[2];

  assign rd[0] = b0.drdata; assign rdy[0] = b0.dready; assign er[0] = b0.err; assign era[0] = b0.err_addr;
  assign rd[1] = b1.drdata; assign rdy[1] = b1.dready; assign er[1] = b1.err; assign era[1] = b1.err_addr;
  assign rd[2] = b2.drdata; assign rdy[2] = b2.dready; assign er[2] = b2.err; assign era[2] = b2.err_addr;

  fwrisc_dmem_target #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(0))
    dut0 (.clock(clock), .reset(reset), .bus(b0));
  fwrisc_dmem_target #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(1))
    dut1 (.clock(clock), .reset(reset), .bus(b1));
  fwrisc_dmem_target #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(15))
    dut2 (.clock(clock), .reset(reset), .bus(b2));

  logic [31:0] mem_m [WORDS];
  logic        err_m;
  logic [31:0] err_addr_m;
  logic [31:0] got [3];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 15;
  endfunction

  function automatic logic [31:0] model_access(input logic [31:0] a, input logic w,
                                               input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    int          idx;
    r = 32'h0;
    if (a >= BASE && a < BASE + SPAN) begin
      idx = int'((a - BASE) / 4);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        r = mem_m[idx];
      end
    end else begin
      if (!err_m) err_addr_m = a;
      err_m = 1'b1;
      if (!w) r = 32'hDEAD_BEEF;
    end
    return r;
  endfunction

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input bit perturb);
    bit [2:0] done;
    done = '0;
    @(negedge clock);
    daddr = a; dwrite = w; dwdata = wd; dwstb = st; dvalid = 3'b111;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (!done[i] && rdy[i] === 1'b1) begin
          if (c != ws_of(i) + 1)
            $display("FAIL latency dut%0d: dready after %0d cycles, expected %0d", i, c, ws_of(i) + 1);
          else n_pass++;
          got[i]    = rd[i];
          done[i]   = 1'b1;
          dvalid[i] = 1'b0;
        end else if (rdy[i] !== 1'b0 || rd[i] !== 32'h0) begin
          $display("FAIL idle_outputs dut%0d cycle %0d: dready=%b drdata=%h, expected 0/00000000",
                   i, c, rdy[i], rd[i]);
        end else n_pass++;
      end
      if (perturb) begin
        daddr = $urandom; dwdata = $urandom; dwstb = 4'($urandom); dwrite = 1'($urandom);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!done[i]) $display("FAIL timeout dut%0d: no dready for addr %h, expected one", i, a);
      else n_pass++;
    end
    dvalid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dvalid = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rdy[i] !== 1'b0 || rd[i] !== 32'h0 || er[i] !== 1'b0 || era[i] !== 32'h0)
        $display("FAIL reset dut%0d: dready=%b drdata=%h err=%b err_addr=%h, expected all 0",
                 i, rdy[i], rd[i], er[i], era[i]);
      else n_pass++;
    end
    reset = 1'b0; err_m = 1'b0; err_addr_m = '0;
  endtask

  task automatic test_fill();
    logic [31:0] d;
    for (int w = 0; w < WORDS; w++) begin
      d = $urandom;
      void'(model_access(BASE + 32'(4 * w), 1'b1, d, 4'hF));
      xfer(BASE + 32'(4 * w), 1'b1, d, 4'hF, 1'b0);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] a_tab [4];
    logic [31:0] d_tab [4];
    logic [3:0]  s_tab [4];
    logic [31:0] e_tab [4];
    a_tab = '{32'h8000_0010, 32'h8000_0010, 32'h8000_0012, 32'h8000_0011};
    d_tab = '{32'h1122_3344, 32'h00AA_0000, 32'hFFFF_FFFF, 32'h5555_5555};
    s_tab = '{4'hF,          4'b0100,       4'b0000,       4'b0000};
    e_tab = '{32'h1122_3344, 32'h11AA_3344, 32'h11AA_3344, 32'h11AA_3344};
    for (int k = 0; k < 4; k++) begin
      void'(model_access(a_tab[k], 1'b1, d_tab[k], s_tab[k]));
      xfer(a_tab[k], 1'b1, d_tab[k], s_tab[k], 1'b0);
      xfer(32'h8000_0013 - 32'(k), 1'b0, 32'h0, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== e_tab[k])
          $display("FAIL byte_lanes dut%0d step %0d: read %h, expected %h", i, k, got[i], e_tab[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp;
    exp = model_access(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0);
    xfer(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== 32'hDEAD_BEEF || got[i] !== exp)
        $display("FAIL oor_read dut%0d: read %h, expected deadbeef", i, got[i]);
      else n_pass++;
    end
    void'(model_access(32'h9000_0000, 1'b1, 32'hCAFE_F00D, 4'hF));
    xfer(32'h9000_0000, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0);
    void'(model_access(BASE + SPAN, 1'b1, 32'h0BAD_0BAD, 4'hF));
    xfer(BASE + SPAN, 1'b1, 32'h0BAD_0BAD, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (er[i] !== 1'b1 || era[i] !== 32'h7FFF_FFFC || era[i] !== err_addr_m)
        $display("FAIL oor_err dut%0d: err=%b err_addr=%h, expected 1/7ffffffc", i, er[i], era[i]);
      else n_pass++;
    end
    for (int w = WORDS - 1; w >= 0; w--) begin
      exp = model_access(BASE + 32'(4 * w), 1'b0, 32'h0, 4'h0);
      xfer(BASE + 32'(4 * w), 1'b0, 32'h0, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== exp)
          $display("FAIL sweep dut%0d word %0d: read %h, expected %h", i, w, got[i], exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random(input int n, input bit perturb);
    logic [31:0] a, d, exp;
    logic        w;
    logic [3:0]  s;
    for (int k = 0; k < n; k++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 255));
      w = 1'($urandom); d = $urandom; s = 4'($urandom);
      exp = model_access(a, w, d, s);
      xfer(a, w, d, s, perturb);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ((!w && got[i] !== exp) || er[i] !== err_m || era[i] !== err_addr_m)
          $display("FAIL random dut%0d op %0d addr %h wr %b: rdata=%h err=%b err_addr=%h, expected %h/%b/%h",
                   i, k, a, w, got[i], er[i], era[i], exp, err_m, err_addr_m);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_request();
    logic [31:0] exp;
    @(negedge clock);
    daddr = 32'h8000_0020; dwrite = 1'b1; dwdata = ~mem_m[8]; dwstb = 4'hF; dvalid = 3'b110;
    @(negedge clock);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rdy[i] !== 1'b0 || rd[i] !== 32'h0 || er[i] !== 1'b0 || era[i] !== 32'h0)
        $display("FAIL mid_reset dut%0d: dready=%b drdata=%h err=%b err_addr=%h, expected all 0",
                 i, rdy[i], rd[i], er[i], era[i]);
      else n_pass++;
    end
    dvalid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0; err_m = 1'b0; err_addr_m = '0;
    exp = model_access(32'h8000_0020, 1'b0, 32'h0, 4'h0);
    xfer(32'h8000_0020, 1'b0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== exp)
        $display("FAIL mid_reset_word dut%0d: read %h, expected %h", i, got[i], exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_byte_lanes();
    test_out_of_range();
    test_random(80, 1'b0);
    test_random(20, 1'b1);
    test_reset_mid_request();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
